// File: rtl/icache_pkg.sv
// Shared types and address-field constants for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_FETCH
    } state_e;

    localparam int LINE_W         = 128;
    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_W         = 32;
    localparam int MEM_ADDR_W     = 28;
    localparam int PROC_ADDR_W    = 30;
    localparam int OFF_W          = 2;
    localparam int IDX_LSB        = OFF_W;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: async read by index, sync fill port, async clear of valid bits only.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_line_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_line_i
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] line_q [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data carry no reset; a cleared valid bit masks whatever they hold.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            line_q[wr_idx_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = line_q[rd_idx_i];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: combinational hits, single-line blocking refill.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_direct
    import icache_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int TAG_W = 25
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   proc_read,
    input  logic                   proc_write,
    input  logic [PROC_ADDR_W-1:0] proc_addr,
    input  logic [WORD_W-1:0]      proc_wdata,
    output logic [WORD_W-1:0]      proc_rdata,
    output logic                   proc_stall,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic [LINE_W-1:0]      mem_rdata,
    input  logic                   mem_ready
`ifdef ICACHE_PERF_CNT_EN
   ,output logic [31:0]            hit_cnt,
    output logic [31:0]            miss_cnt
`endif
);

    localparam int IDX_W = $clog2(SETS);

    state_e                  state_q, state_d;
    logic                    mem_read_q, mem_read_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic [IDX_W-1:0]        req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic [OFF_W-1:0]        req_off;
    logic                    rd_valid;
    logic [TAG_W-1:0]        rd_tag;
    logic [LINE_W-1:0]       rd_line;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0] rd_words;
    logic                    hit;
    logic                    fill_en;

    assign req_off = proc_addr[OFF_W-1:0];
    assign req_idx = proc_addr[IDX_LSB+IDX_W-1:IDX_LSB];
    assign req_tag = proc_addr[PROC_ADDR_W-1:IDX_LSB+IDX_W];

    // The latched line address doubles as the fill index/tag, so a core that
    // changes proc_addr mid-fetch cannot redirect the fill.
    assign fill_en = (state_q == ST_FETCH) && mem_ready;

    icache_line_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .wr_en_i    (fill_en),
        .wr_idx_i   (mem_addr_q[IDX_W-1:0]),
        .wr_tag_i   (mem_addr_q[MEM_ADDR_W-1:IDX_W]),
        .wr_line_i  (mem_rdata)
    );

    assign hit        = rd_valid && (rd_tag == req_tag);
    assign rd_words   = rd_line;
    assign proc_rdata = rd_words[req_off];

    always_comb begin
        state_d    = state_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        proc_stall = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (proc_read && !hit) begin
                    proc_stall = 1'b1;
                    state_d    = ST_FETCH;
                    mem_read_d = 1'b1;
                    mem_addr_d = proc_addr[PROC_ADDR_W-1:IDX_LSB];
                end
            end
            ST_FETCH: begin
                proc_stall = 1'b1;
                if (mem_ready) begin
                    state_d    = ST_IDLE;
                    mem_read_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = 1'b0;
    assign mem_wdata = '0;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == ST_IDLE && proc_read && hit && hit_cnt_q != '1)
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == ST_IDLE && state_d == ST_FETCH && miss_cnt_q != '1)
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    // Write-side core inputs are intentionally ignored: instruction space is immutable.
    logic unused_write_side;
    assign unused_write_side = ^{proc_write, proc_wdata};

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed table, multi-cycle corner sequences,
// and randomized accesses checked against a line-residency model.
module tb_icache_direct;

    localparam int SETS = 8;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    icache_direct #(.SETS(SETS), .TAG_W(25)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_CNT_EN
       ,.hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model state: respond mem_lat cycles after mem_read is first seen.
    bit mem_auto;
    int mem_lat;
    int mem_cnt;

    // Reference model: which line address is resident in each set.
    bit          ref_vld  [SETS];
    int unsigned ref_line [SETS];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic        rdy;
        logic        stall;
        logic [31:0] data;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [31:0] word_val(input logic [29:0] w);
        return {w[27:0], 4'h9} ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [127:0] line_val(input logic [27:0] la);
        return {word_val({la, 2'd3}), word_val({la, 2'd2}),
                word_val({la, 2'd1}), word_val({la, 2'd0})};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One cycle: advance past the rising edge, then let the memory model react.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (mem_ready) mem_ready = 1'b0;
        if (mem_auto && rst_n && mem_read) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                mem_rdata = line_val(mem_addr);
                mem_cnt   = 0;
            end
        end else begin
            mem_cnt = 0;
        end
    endtask

    function automatic bit model_hit(input logic [29:0] a);
        int unsigned la = 32'(a) >> 2;
        return ref_vld[la % SETS] && ref_line[la % SETS] == la;
    endfunction

    function automatic void model_fill(input int unsigned la);
        ref_vld[la % SETS]  = 1'b1;
        ref_line[la % SETS] = la;
    endfunction

    task automatic reset_dut();
        rst_n      = 1'b0;
        proc_read  = 1'b1;
        proc_addr  = 30'h5;
        mem_ready  = 1'b0;
        mem_auto   = 1'b1;
        #1;
        chk1("rst_stall_read", proc_stall, 1'b1);
        chk1("rst_mem_read", mem_read, 1'b0);
        chkw("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk1("rst_mem_write", mem_write, 1'b0);
        chkw("rst_mem_wdata", mem_wdata, 128'(0));
`ifdef ICACHE_PERF_CNT_EN
        chkw("rst_hit_cnt", 128'(hit_cnt), 128'(0));
        chkw("rst_miss_cnt", 128'(miss_cnt), 128'(0));
`endif
        proc_read = 1'b0;
        #1;
        chk1("rst_stall_idle", proc_stall, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int s = 0; s < SETS; s++) ref_vld[s] = 1'b0;
    endtask

    // Hold a read until served; a miss must stall exactly cycles 0..lat (ready arrives in cycle lat).
    task automatic access(input logic [29:0] a);
        bit exp_miss;
        int n;
        exp_miss = !model_hit(a);
        cyc();
        proc_read  = 1'b1;
        proc_write = 1'($urandom);
        proc_addr  = a;
        #1;
        chk1("first_cycle_stall", proc_stall, exp_miss);
        if (proc_stall) begin
            n = 0;
            while (proc_stall && n < 60) begin
                cyc();
                #1;
                if (n == 0) begin
                    chk1("miss_mem_read", mem_read, 1'b1);
                    chkw("miss_mem_addr", 128'(mem_addr), 128'(a[29:2]));
                end
                n++;
            end
            chkw("miss_stall_cycles", 128'(n), 128'(mem_lat + 1));
            model_fill(32'(a) >> 2);
        end
        chkw("read_data", 128'(proc_rdata), 128'(word_val(a)));
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        mem_ready  = 1'b0;
        mem_auto   = 1'b1;
        mem_lat    = 3;
        mem_cnt    = 0;

        tbl[0] = '{1'b1, 1'b0, 30'h4,  1'b0, 1'b0, word_val(30'h4)};
        tbl[1] = '{1'b1, 1'b0, 30'h6,  1'b0, 1'b0, word_val(30'h6)};
        tbl[2] = '{1'b1, 1'b1, 30'h7,  1'b0, 1'b0, word_val(30'h7)};
        tbl[3] = '{1'b0, 1'b0, 30'h25, 1'b1, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 30'h25, 1'b0, 1'b0, 32'h0};

        // Reset state and cold miss on 0x5.
        reset_dut();
        access(30'h5);

        // Hits on the freshly filled line, a stray mem_ready in IDLE, and ignored writes.
        for (int i = 0; i < 5; i++) begin
            cyc();
            proc_read  = tbl[i].rd;
            proc_write = tbl[i].wr;
            proc_wdata = 32'($urandom);
            proc_addr  = tbl[i].addr;
            if (tbl[i].rdy) begin
                mem_ready = 1'b1;
                mem_rdata = '1;
            end
            #1;
            chk1("tbl_stall", proc_stall, tbl[i].stall);
            if (tbl[i].rd) chkw("tbl_data", 128'(proc_rdata), 128'(tbl[i].data));
        end
`ifdef ICACHE_PERF_CNT_EN
        chkw("perf_miss_cnt", 128'(miss_cnt), 128'(1));
        chkw("perf_hit_cnt", 128'(hit_cnt), 128'(4));
`endif
        access(30'h5);

        // Conflict in set 1: 0x25 evicts line 1, so 0x5 misses again.
        access(30'h25);
        access(30'h5);

        // Address change mid-fetch: the fill lands in the latched set 1.
        reset_dut();
        cyc();
        proc_read = 1'b1;
        proc_addr = 30'h5;
        #1;
        chk1("midf_stall0", proc_stall, 1'b1);
        cyc();
        proc_addr = 30'h40;
        #1;
        chk1("midf_stall1", proc_stall, 1'b1);
        chkw("midf_mem_addr", 128'(mem_addr), 128'(28'h1));
        n = 0;
        while (mem_read && n < 20) begin
            cyc();
            #1;
            n++;
        end
        chk1("midf_fill_done", n < 20, 1'b1);
        chk1("midf_restall", proc_stall, 1'b1);
        model_fill(32'h1);
        cyc();
        #1;
        chk1("midf_new_req", mem_read, 1'b1);
        chkw("midf_new_addr", 128'(mem_addr), 128'(28'h10));
        n = 0;
        while (proc_stall && n < 20) begin
            cyc();
            #1;
            n++;
        end
        chk1("midf_new_done", n < 20, 1'b1);
        chkw("midf_new_data", 128'(proc_rdata), 128'(word_val(30'h40)));
        model_fill(32'h10);
        access(30'h5);

        // Reset mid-fetch: request abandoned, late mem_ready ignored, set stays invalid.
        cyc();
        proc_read = 1'b1;
        proc_addr = 30'h65;
        #1;
        chk1("rmf_miss", proc_stall, 1'b1);
        cyc();
        #1;
        chk1("rmf_mem_read", mem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rmf_mem_read_clr", mem_read, 1'b0);
        chkw("rmf_mem_addr_clr", 128'(mem_addr), 128'(0));
        cyc();
        rst_n     = 1'b1;
        proc_read = 1'b0;
        mem_auto  = 1'b0;
        for (int s = 0; s < SETS; s++) ref_vld[s] = 1'b0;
        cyc();
        mem_ready = 1'b1;
        mem_rdata = line_val(28'h19);
        #1;
        chk1("rmf_late_ready", proc_stall, 1'b0);
        cyc();
        mem_auto = 1'b1;
        access(30'h5);
        access(30'h65);

        // Randomized accesses over a few tags per set to mix hits, misses and conflicts.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                cyc();
                proc_read  = 1'b0;
                proc_write = 1'($urandom);
                proc_addr  = 30'($urandom);
                #1;
                chk1("rand_idle_stall", proc_stall, 1'b0);
            end else begin
                mem_lat = $urandom_range(1, 4);
                access(30'(($urandom_range(0, 2) << 5) | ($urandom_range(0, 7) << 2)
                           | $urandom_range(0, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
